// File: rtl/double_dabble_pkg.sv
// Shared types for the double-dabble binary-to-BCD converter.
// Holds the BCD digit type, the converter state encoding and the add-3 correction.
package double_dabble_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // A digit of 5..9 would overflow past 9 when doubled; adding 3 makes the carry land in the next digit.
    function automatic bcd_digit_t add3(input bcd_digit_t d);
        return (d >= bcd_digit_t'(5)) ? bcd_digit_t'(d + bcd_digit_t'(3)) : d;
    endfunction

endpackage

// File: rtl/double_dabble_add3.sv
// Per-digit add-3 correction, purely combinational (zero latency).
// No flow control; one instance per accumulator digit.
module bcd_add3
    import double_dabble_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);

    assign dout = add3(din);

endmodule

// File: rtl/double_dabble.sv
// Iterative binary-to-BCD converter: one shift-and-add-3 step per clock, result WIDTH edges after write.
// No backpressure: a write always wins, aborting any conversion in flight.
module double_dabble
    import double_dabble_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DIGIT_COUNT = 6
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                write,
    input  logic [WIDTH-1:0]                    data,
    output logic                                done,
    output logic [DIGIT_COUNT-1:0][BCD_W-1:0]   digits
);

    localparam int ACC_W = BCD_W * DIGIT_COUNT;
    localparam int K_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   digits_q, digits_d;
    logic               done_q, done_d;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   acc_shifted;

    for (genvar i = 0; i < DIGIT_COUNT; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (acc_q[i*BCD_W +: BCD_W]),
            .dout (acc_adj[i*BCD_W +: BCD_W])
        );
    end

    // Anything shifted out of the top digit is dropped, giving value mod 10^DIGIT_COUNT.
    assign acc_shifted = {acc_adj[ACC_W-2:0], shift_q[WIDTH-1]};

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        digits_d = digits_q;
        done_d   = done_q;
        if (write) begin
            shift_d = data;
            acc_d   = '0;
            k_d     = '0;
            done_d  = 1'b0;
            state_d = BUSY;
        end else if (state_q == BUSY) begin
            acc_d   = acc_shifted;
            shift_d = shift_q << 1;
            k_d     = k_q + 1'b1;
            if (k_q == K_LAST) begin
                digits_d = acc_shifted;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            k_q      <= '0;
            shift_q  <= '0;
            acc_q    <= '0;
            digits_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            digits_q <= digits_d;
            done_q   <= done_d;
        end
    end

    assign done   = done_q;
    assign digits = digits_q;

endmodule

// File: tb/tb_double_dabble.sv
// Scoreboard bench for double_dabble: defaults (6 digits) and a truncated 3-digit instance side by side.
module tb_double_dabble;
    import double_dabble_pkg::*;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic              write = 1'b0;
    logic [15:0]       data  = '0;
    logic              done6, done3;
    logic [5:0][3:0]   digits6;
    logic [2:0][3:0]   digits3;

    double_dabble #(.WIDTH(16), .DIGIT_COUNT(6)) u_dut6 (
        .clk(clk), .reset(reset), .write(write), .data(data),
        .done(done6), .digits(digits6)
    );

    double_dabble #(.WIDTH(16), .DIGIT_COUNT(3)) u_dut3 (
        .clk(clk), .reset(reset), .write(write), .data(data),
        .done(done3), .digits(digits3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [23:0] dig;
        int          cyc;
    } exp_t;

    exp_t        q6[$];
    exp_t        q3[$];
    int          total = 0;
    int          bad   = 0;
    logic [23:0] last6 = '0;
    logic [11:0] last3 = '0;

    function automatic logic [23:0] ref_bcd(input int v);
        logic [23:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic p6, p3;
        exp_t e;
        p6 = 1'b0;
        p3 = 1'b0;
        forever begin
            @(negedge clk);
            if (done6 && !p6) begin
                if (q6.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done6: done rose with nothing outstanding, digits=%h", digits6);
                end else begin
                    e = q6.pop_front();
                    chk("digits6", 24'(digits6), e.dig);
                    chk("latency6", 24'(cyc), 24'(e.cyc));
                end
            end
            if (done3 && !p3) begin
                if (q3.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_done3: done rose with nothing outstanding, digits=%h", digits3);
                end else begin
                    e = q3.pop_front();
                    chk("digits3", 24'(digits3), e.dig);
                    chk("latency3", 24'(cyc), 24'(e.cyc));
                end
            end
            p6 = done6;
            p3 = done3;
        end
    endtask

    // Called just after a negedge; the following posedge is E0.
    task automatic do_write(input logic [15:0] v, input logic [23:0] exp6, input bit expect_hi);
        exp_t e;
        if (expect_hi) begin
            chk("done_held6", 24'(done6), 24'd1);
            chk("done_held3", 24'(done3), 24'd1);
        end
        write = 1'b1;
        data  = v;
        e.dig = exp6;
        e.cyc = cyc + 1 + 16;
        q6.push_back(e);
        e.dig = {12'h000, exp6[11:0]};
        q3.push_back(e);
        @(negedge clk);
        write = 1'b0;
        data  = 16'($urandom);
        chk("done_low6", 24'(done6), 24'd0);
        chk("done_low3", 24'(done3), 24'd0);
        chk("hold6", 24'(digits6), last6);
        chk("hold3", 24'(digits3), {12'h000, last3});
    endtask

    task automatic wait_done(input logic [23:0] exp6);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (q6.size() == 0 && q3.size() == 0) break;
        end
        total++;
        if (q6.size() != 0 || q3.size() != 0) begin
            bad++;
            $display("FAIL timeout: outstanding6=%0d outstanding3=%0d required 0", q6.size(), q3.size());
            q6.delete();
            q3.delete();
        end
        last6 = exp6;
        last3 = exp6[11:0];
    endtask

    task automatic convert(input logic [15:0] v, input logic [23:0] exp6, input bit expect_hi);
        do_write(v, exp6, expect_hi);
        wait_done(exp6);
    endtask

    typedef struct {
        logic [15:0] v;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[9] = '{
        '{16'd0,     24'h000000},
        '{16'd65535, 24'h065535},
        '{16'd1234,  24'h001234},
        '{16'd9999,  24'h009999},
        '{16'd10000, 24'h010000},
        '{16'd1,     24'h000001},
        '{16'd99,    24'h000099},
        '{16'd1000,  24'h001000},
        '{16'd65534, 24'h065534}
    };

    initial begin
        logic [15:0] rv;
        exp_t        dummy;
        fork
            monitor();
        join_none

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_digits6", 24'(digits6), 24'h0);
        chk("reset_done6", 24'(done6), 24'h0);
        chk("reset_digits3", 24'(digits3), 24'h0);
        chk("reset_done3", 24'(done3), 24'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            convert(vecs[i].v, vecs[i].exp, i != 0);
        end
        chk("mod1000_65534", 24'(digits3), 24'h000534);

        // Abort: second write lands at E0+5 of the first.
        do_write(16'd4321, 24'h004321, 1'b1);
        repeat (4) @(negedge clk);
        chk("abort_done_low", 24'(done6), 24'd0);
        dummy = q6.pop_back();
        dummy = q3.pop_back();
        convert(16'd7, 24'h000007, 1'b0);

        convert(16'd65535, 24'h065535, 1'b1);
        chk("trunc_65535", 24'(digits3), 24'h000535);

        // Reset at E0+8 of a conversion of 500.
        do_write(16'd500, 24'h000500, 1'b1);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        q6.delete();
        q3.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_digits6", 24'(digits6), 24'h0);
        chk("midreset_done6", 24'(done6), 24'h0);
        chk("midreset_digits3", 24'(digits3), 24'h0);
        last6 = '0;
        last3 = '0;
        repeat (25) @(negedge clk);
        chk("midreset_quiet", 24'(done6), 24'h0);

        for (int i = 0; i < 2000; i++) begin
            rv = 16'($urandom_range(0, 65535));
            convert(rv, ref_bcd(int'(rv)), i != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
